// File: rtl/nco_sweep_ctrl_if.sv
// Sweep controller bus: configuration and control from the host, swept phase increment and status back.
interface nco_sweep_ctrl_if #(
  parameter int WIDTH   = 64,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic               mode;
  logic [WIDTH-1:0]   f_start;
  logic [WIDTH-1:0]   f_stop;
  logic [WIDTH-1:0]   f_step;
  logic [DWELL_W-1:0] dwell;
  logic [WIDTH-1:0]   phase_inc_carr;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell,
    input  phase_inc_carr, busy, done
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell,
    output phase_inc_carr, busy, done
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Steps an NCO phase increment from f_start to f_stop in f_step increments,
// holding each point dwell+1 cycles, in single-shot or continuous mode.
module nco_sweep_ctrl #(
  parameter int WIDTH   = 64,
  parameter int DWELL_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  nco_sweep_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE,
    DWELL
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   phaseInc_q, phaseInc_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   fStart_q, fStart_d;
  logic [WIDTH-1:0]   fStep_q, fStep_d;
  logic [WIDTH-1:0]   stopEff_q, stopEff_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // One extra bit so a step past the top of the range clamps instead of wrapping.
  logic [WIDTH:0] stepSum;
  assign stepSum = {1'b0, phaseInc_q} + {1'b0, fStep_q};

  always_comb begin
    state_d    = state_q;
    phaseInc_d = phaseInc_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    mode_d     = mode_q;
    fStart_d   = fStart_q;
    fStep_d    = fStep_q;
    stopEff_d  = stopEff_q;
    dwell_d    = dwell_q;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_d     = bus.mode;
            fStart_d   = bus.f_start;
            fStep_d    = bus.f_step;
            dwell_d    = bus.dwell;
            stopEff_d  = (bus.f_stop > bus.f_start) ? bus.f_stop : bus.f_start;
            phaseInc_d = bus.f_start;
            cnt_d      = bus.dwell;
            state_d    = DWELL;
          end
        end
        DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (phaseInc_q != stopEff_q) begin
            // A zero step would never reach the stop point, so jump straight to it.
            if (fStep_q == '0 || stepSum > {1'b0, stopEff_q}) begin
              phaseInc_d = stopEff_q;
            end else begin
              phaseInc_d = stepSum[WIDTH-1:0];
            end
            cnt_d = dwell_q;
          end else begin
            done_d = 1'b1;
            if (mode_q) begin
              phaseInc_d = fStart_q;
              cnt_d      = dwell_q;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phaseInc_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= 1'b0;
      fStart_q   <= '0;
      fStep_q    <= '0;
      stopEff_q  <= '0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      phaseInc_q <= phaseInc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mode_q     <= mode_d;
      fStart_q   <= fStart_d;
      fStep_q    <= fStep_d;
      stopEff_q  <= stopEff_d;
      dwell_q    <= dwell_d;
    end
  end

  assign bus.phase_inc_carr = phaseInc_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the phase-increment width (matches the NCO phase accumulator).
REQ-002 SHALL have parameter DWELL_W, default 16, giving the dwell counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a sweep, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1 bit: terminates any sweep in progress.
REQ-007 SHALL have port mode, input, 1 bit: 0 = single sweep, 1 = continuous (repeat).
REQ-008 SHALL have port f_start, input, WIDTH bits: first phase increment.
REQ-009 SHALL have port f_stop, input, WIDTH bits: final phase increment.
REQ-010 SHALL have port f_step, input, WIDTH bits: increment added per step.
REQ-011 SHALL have port dwell, input, DWELL_W bits: each frequency is held dwell+1 cycles.
REQ-012 SHALL have port phase_inc_carr, output, WIDTH bits: registered phase increment driving the NCO.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at the end of each completed pass.

Function
REQ-015 SHALL implement the states IDLE and DWELL; all outputs SHALL be registered.
REQ-016 SHALL, in IDLE with start=1 and abort=0, latch mode, f_start, f_step and dwell, load phase_inc_carr=f_start and cnt=dwell, and enter DWELL; busy SHALL be 1 from the following cycle.
REQ-017 SHALL, at start, latch stop_eff=f_stop if f_stop>f_start, else stop_eff=f_start (a single-point sweep).
REQ-018 SHALL ignore config inputs and start while busy; later input changes SHALL NOT affect a running sweep.
REQ-019 SHALL, in DWELL with cnt!=0, decrement cnt by 1 and hold phase_inc_carr.
REQ-020 SHALL, in DWELL with cnt==0 and phase_inc_carr!=stop_eff, compute next=phase_inc_carr+f_step in WIDTH+1 bits, load phase_inc_carr=min(next, stop_eff), and reload cnt=dwell.
REQ-021 SHALL treat f_step==0 as a direct jump to stop_eff, so every sweep terminates.
REQ-022 SHALL, in DWELL with cnt==0 and phase_inc_carr==stop_eff, assert done for one cycle; if mode=0 it SHALL enter IDLE (busy=0, phase_inc_carr holds stop_eff).
REQ-023 SHALL, in the REQ-022 condition with mode=1, reload phase_inc_carr=f_start and cnt=dwell, and remain in DWELL.
REQ-024 SHALL, on abort=1 in any state, enter IDLE on that edge with phase_inc_carr unchanged and no done pulse; abort SHALL take priority over start and over step/end events in the same cycle.
REQ-025 SHALL keep phase_inc_carr unchanged in IDLE.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, force state=IDLE, phase_inc_carr=0, cnt=0, busy=0, done=0, and latched config=0; this overrides all other inputs, including mid-sweep.
REQ-027 SHALL honour start on the first edge after rst_n returns to 1.

Verification
REQ-028 SHALL verify basic sweep: f_start=100, f_stop=130, f_step=10, dwell=2, mode=0, start pulse -> phase_inc_carr 100,110,120,130, each held 3 cycles; done pulses once, 12 edges after start is sampled; busy then falls; output stays at 130.
REQ-029 SHALL verify clamp and overflow: f_start=0, f_stop=25, f_step=10, dwell=0 -> 0,10,20,25 then done. Also f_start=2^64-16, f_stop=2^64-1, f_step=10 -> 2^64-16, 2^64-6, 2^64-1, with no wrap to a small value.
REQ-030 SHALL verify degenerate cases: f_start=50, f_stop=40 -> single point at 50 held dwell+1 cycles, then done. Also f_step=0 with start=0, stop=8 -> 0 then 8.
REQ-031 SHALL verify continuous mode: mode=1 with the REQ-028 values -> 100..130 repeating, with a done pulse after each 130 dwell and busy held high. Then abort=1 -> IDLE next edge, busy=0, no done, output frozen.
REQ-032 SHALL verify reset and collisions: rst_n=0 mid-sweep -> phase_inc_carr=0, busy=0 on that edge. Start and abort in the same IDLE cycle -> stays IDLE. Start while busy -> ignored; sweep timing unchanged.
